// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: instruction size and the
// 2-bit saturating branch counter with its update helpers.
package pc_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  function automatic ctr_t sat_inc(ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_gen_btb_if.sv
// Control/redirect inputs and fetch-address outputs of the PC generator.
interface pc_gen_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] pc_next;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, trap_valid, trap_vec, redirect_valid, redirect_target,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc_if, pc_next, pred_taken, pred_target
  );

  modport slave (
    input  stall, trap_valid, trap_vec, redirect_valid, redirect_target,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc_if, pc_next, pred_taken, pred_target
  );
endinterface

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// synchronous training from execute. Only valid bits are reset.
module btb_dm
  import pc_pkg::*;
#(
  parameter  int unsigned XLEN        = 32,
  parameter  int unsigned BTB_ENTRIES = 16,
  localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES),
  localparam int unsigned TAG_W       = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  typedef struct packed {
    logic            valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] target;
    ctr_t            ctr;
  } btb_entry_t;

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  btb_entry_t       l_ent, u_ent;
  logic             l_hit, u_hit;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX_W+2];

  assign l_ent = btb_q[l_idx];
  assign u_ent = btb_q[u_idx];
  assign l_hit = l_ent.valid && (l_ent.tag == l_tag);
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  // Lookup sees pre-update contents; a same-index update lands at the edge.
  assign pred_taken  = l_hit && l_ent.ctr[1];
  assign pred_target = l_hit ? l_ent.target : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          btb_q[u_idx].ctr    <= sat_inc(u_ent.ctr);
          btb_q[u_idx].target <= upd_target;
        end else begin
          btb_q[u_idx].ctr <= sat_dec(u_ent.ctr);
        end
      end else if (upd_taken) begin
        btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WT};
      end
    end
  end

  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: rtl/pc_gen_btb.sv
// IF-stage PC register with prioritised next-PC selection:
// trap > redirect > stall > BTB prediction > sequential.
module pc_gen_btb
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input logic         clk,
  input logic         reset,
  pc_gen_btb_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_vec_al, redirect_al, upd_target_al;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  assign trap_vec_al   = {bus.trap_vec[XLEN-1:2], 2'b00};
  assign redirect_al   = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign upd_target_al = {bus.upd_target[XLEN-1:2], 2'b00};

  btb_dm #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (pc_q),
    .upd_valid   (bus.upd_valid),
    .upd_pc      (bus.upd_pc),
    .upd_target  (upd_target_al),
    .upd_taken   (bus.upd_taken),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  always_comb begin
    pc_d = pc_q + XLEN'(INSN_BYTES);
    if (bus.trap_valid) begin
      pc_d = trap_vec_al;
    end else if (bus.redirect_valid) begin
      pc_d = redirect_al;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_if       = pc_q;
  assign bus.pc_next     = pc_d;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;

  logic unused_low_bits;
  assign unused_low_bits = ^{bus.trap_vec[1:0], bus.redirect_target[1:0], bus.upd_target[1:0]};

endmodule

// File: tb/tb_pc_gen_btb.sv
// Self-checking bench for pc_gen_btb: directed scenarios plus randomized traffic
// checked against a table-level model of the predictor and next-PC rules.
module tb_pc_gen_btb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ENT  = 16;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_btb_if #(.XLEN(XLEN)) bus ();

  pc_gen_btb #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .BTB_ENTRIES  (ENT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one record per table slot, addressed by word number.
  bit          m_valid  [ENT];
  logic [31:0] m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  logic [31:0] m_pc;

  function automatic int slot_of(logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic void m_reset();
    m_pc = RV;
    for (int i = 0; i < int'(ENT); i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int s = slot_of(pc);
    bit hit = m_valid[s] && (m_tag[s] == tag_of(pc));
    t   = hit && (m_ctr[s] >= 2);
    tgt = hit ? m_target[s] : 32'h0;
  endfunction

  function automatic void m_train(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    int s = slot_of(pc);
    bit hit = m_valid[s] && (m_tag[s] == tag_of(pc));
    if (hit) begin
      if (taken) begin
        m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_target[s] = tgt & ~32'h3;
      end else begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[s]  = 1'b1;
      m_tag[s]    = tag_of(pc);
      m_target[s] = tgt & ~32'h3;
      m_ctr[s]    = 2;
    end
  endfunction

  function automatic logic [31:0] m_next();
    bit t;
    logic [31:0] tgt;
    m_lookup(m_pc, t, tgt);
    if (bus.trap_valid) return bus.trap_vec & ~32'h3;
    if (bus.redirect_valid) return bus.redirect_target & ~32'h3;
    if (bus.stall) return m_pc;
    if (t) return tgt;
    return m_pc + 32'd4;
  endfunction

  // Advance one clock, keeping the model in step with the driven inputs.
  task automatic adv();
    logic [31:0] nx;
    if (reset) begin
      m_reset();
    end else begin
      nx = m_next();
      if (bus.upd_valid) m_train(bus.upd_pc, bus.upd_target, bus.upd_taken);
      m_pc = nx;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.stall           = 1'b0;
    bus.trap_valid      = 1'b0;
    bus.trap_vec        = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_target      = '0;
    bus.upd_taken       = 1'b0;
  endtask

  task automatic goto(input logic [31:0] addr);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = addr;
    adv();
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = taken;
    adv();
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.pc_if !== RV) begin
      n_errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_if, RV);
    end
    n_checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_pred: got %b/%h expected 0/0", bus.pred_taken, bus.pred_target);
    end
    reset = 1'b0;
    m_reset();
    #1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.pc_if !== 32'(4 * i) || bus.pred_taken !== 1'b0) begin
        n_errors++;
        $display("FAIL seq_%0d: got pc %h pred %b expected pc %h pred 0",
                 i, bus.pc_if, bus.pred_taken, 4 * i);
      end
      adv();
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.pc_if !== 32'h10 || bus.pc_next !== 32'h10) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: got pc %h next %h expected 10/10", i, bus.pc_if, bus.pc_next);
      end
      adv();
    end
    bus.stall = 1'b0;
    n_checks++;
    if (bus.pc_if !== 32'h10) begin
      n_errors++; $display("FAIL stall_last: got %h expected 10", bus.pc_if);
    end
    adv();
    n_checks++;
    if (bus.pc_if !== 32'h14) begin
      n_errors++; $display("FAIL stall_release: got %h expected 14", bus.pc_if);
    end
  endtask

  task automatic test_priority();
    bus.trap_valid      = 1'b1;
    bus.trap_vec        = 32'h80;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    bus.stall           = 1'b1;
    #1;
    n_checks++;
    if (bus.pc_next !== 32'h80) begin
      n_errors++; $display("FAIL prio_trap_next: got %h expected 80", bus.pc_next);
    end
    adv();
    bus.trap_valid = 1'b0;
    n_checks++;
    if (bus.pc_if !== 32'h80) begin
      n_errors++; $display("FAIL prio_trap_pc: got %h expected 80", bus.pc_if);
    end
    // Redirect beats stall; low target bits are dropped.
    bus.redirect_target = 32'h203;
    adv();
    set_idle();
    #1;
    n_checks++;
    if (bus.pc_if !== 32'h200) begin
      n_errors++; $display("FAIL prio_redirect: got %h expected 200", bus.pc_if);
    end
  endtask

  task automatic test_btb_alloc();
    train(32'h40, 32'h103, 1'b1);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h100 || bus.pc_next !== 32'h100) begin
      n_errors++;
      $display("FAIL alloc_pred: got %b/%h next %h expected 1/100 next 100",
               bus.pred_taken, bus.pred_target, bus.pc_next);
    end
    adv();
    n_checks++;
    if (bus.pc_if !== 32'h100) begin
      n_errors++; $display("FAIL alloc_follow: got %h expected 100", bus.pc_if);
    end
  endtask

  task automatic test_counter();
    train(32'h40, 32'h100, 1'b0);
    train(32'h40, 32'h100, 1'b0);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b0 || bus.pc_next !== 32'h44) begin
      n_errors++;
      $display("FAIL ctr_down: got %b next %h expected 0 next 44", bus.pred_taken, bus.pc_next);
    end
    repeat (3) train(32'h40, 32'h100, 1'b1);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b1) begin
      n_errors++; $display("FAIL ctr_up: got %b expected 1", bus.pred_taken);
    end
    train(32'h40, 32'h100, 1'b1);
    train(32'h40, 32'h100, 1'b0);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b1) begin
      n_errors++; $display("FAIL ctr_sat_hi: got %b expected 1", bus.pred_taken);
    end
    train(32'h40, 32'h100, 1'b0);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b0) begin
      n_errors++; $display("FAIL ctr_weak_nt: got %b expected 0", bus.pred_taken);
    end
  endtask

  task automatic test_alias();
    train(32'h80, 32'h204, 1'b1);
    goto(32'h40);
    n_checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
      n_errors++;
      $display("FAIL alias_evict: got %b/%h expected 0/0", bus.pred_taken, bus.pred_target);
    end
    goto(32'h80);
    n_checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h204) begin
      n_errors++;
      $display("FAIL alias_new: got %b/%h expected 1/204", bus.pred_taken, bus.pred_target);
    end
    // Same-slot lookup during update sees the old counter.
    bus.stall      = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h80;
    bus.upd_target = 32'h0;
    bus.upd_taken  = 1'b0;
    #1;
    n_checks++;
    if (bus.pred_taken !== 1'b1) begin
      n_errors++; $display("FAIL same_slot_pre: got %b expected 1", bus.pred_taken);
    end
    adv();
    bus.upd_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.pred_taken !== 1'b0 || bus.pc_if !== 32'h80) begin
      n_errors++;
      $display("FAIL same_slot_post: got %b pc %h expected 0 pc 80", bus.pred_taken, bus.pc_if);
    end
    bus.stall = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    n_checks++;
    if (bus.pc_next !== 32'h0 || bus.pred_taken !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_next: got %h pred %b expected 0 pred 0", bus.pc_next, bus.pred_taken);
    end
    adv();
    n_checks++;
    if (bus.pc_if !== 32'h0) begin
      n_errors++; $display("FAIL wrap_pc: got %h expected 0", bus.pc_if);
    end
  endtask

  task automatic test_mid_reset();
    train(32'h80, 32'h204, 1'b1);
    goto(32'h80);
    n_checks++;
    if (bus.pred_taken !== 1'b1) begin
      n_errors++; $display("FAIL mrst_setup: got %b expected 1", bus.pred_taken);
    end
    #2;
    reset          = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0;
    bus.upd_target = 32'h300;
    bus.upd_taken  = 1'b1;
    #1;
    n_checks++;
    if (bus.pc_if !== RV || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
      n_errors++;
      $display("FAIL mrst_async: got pc %h pred %b/%h expected %h 0/0",
               bus.pc_if, bus.pred_taken, bus.pred_target, RV);
    end
    adv();
    reset = 1'b0;
    set_idle();
    #1;
    n_checks++;
    if (bus.pc_if !== RV || bus.pred_taken !== 1'b0) begin
      n_errors++;
      $display("FAIL mrst_drop_train: got pc %h pred %b expected %h 0", bus.pc_if, bus.pred_taken, RV);
    end
    goto(32'h80);
    n_checks++;
    if (bus.pred_taken !== 1'b0) begin
      n_errors++; $display("FAIL mrst_cleared: got %b expected 0", bus.pred_taken);
    end
  endtask

  task automatic test_random();
    bit          et;
    logic [31:0] etg, en;
    for (int c = 0; c < 400; c++) begin
      bus.stall           = ($urandom_range(3) == 0);
      bus.trap_valid      = ($urandom_range(31) == 0);
      bus.trap_vec        = 32'($urandom_range(32'h3FF));
      bus.redirect_valid  = ($urandom_range(7) == 0);
      bus.redirect_target = 32'($urandom_range(32'h3FF));
      bus.upd_valid       = ($urandom_range(1) == 0);
      bus.upd_pc          = 32'($urandom_range(32'h3FF)) & ~32'h3;
      bus.upd_target      = 32'($urandom_range(32'h3FF));
      bus.upd_taken       = ($urandom_range(2) != 0);
      #1;
      m_lookup(m_pc, et, etg);
      en = m_next();
      n_checks++;
      if (bus.pc_if !== m_pc) begin
        n_errors++; $display("FAIL rnd_pc @%0d: got %h expected %h", c, bus.pc_if, m_pc);
      end
      n_checks++;
      if (bus.pred_taken !== et || bus.pred_target !== etg) begin
        n_errors++;
        $display("FAIL rnd_pred @%0d: got %b/%h expected %b/%h", c, bus.pred_taken,
                 bus.pred_target, et, etg);
      end
      n_checks++;
      if (bus.pc_next !== en) begin
        n_errors++; $display("FAIL rnd_next @%0d: got %h expected %h", c, bus.pc_next, en);
      end
      adv();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_priority();
    test_btb_alloc();
    test_counter();
    test_alias();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
- Parametrised fetch-address generator; next generation of the single-redirect PC register.
- Holds the IF-stage PC and selects the next PC from prioritised sources: trap vector, execute-stage redirect, stall hold, BTB prediction, sequential increment.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained from execute.
- Sits between the hazard unit / execute stage and instruction memory.

Parameters:
- XLEN, 32, address/data width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2.
- IDX_W, $clog2(BTB_ENTRIES), BTB index width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC (IF/ID hazard).
- trap_valid  input  1  exception/interrupt redirect.
- trap_vec  input  XLEN  trap handler address.
- redirect_valid  input  1  execute-resolved branch/jump mispredict redirect.
- redirect_target  input  XLEN  corrected fetch address.
- upd_valid  input  1  BTB training strobe from execute (one per resolved branch/jump).
- upd_pc  input  XLEN  PC of the resolved control instruction.
- upd_target  input  XLEN  resolved target.
- upd_taken  input  1  resolved direction.
- pc_if  output  XLEN  current fetch PC (registered).
- pc_next  output  XLEN  PC to be loaded at next edge (combinational).
- pred_taken  output  1  BTB predicts pc_if taken (combinational); travels down the pipe.
- pred_target  output  XLEN  predicted target for pc_if; valid when pred_taken=1.

Behaviour:
- Reset: asynchronous, active-high; clock clk. pc_if=RESET_VECTOR; all BTB valid bits cleared. Hence pred_taken=0 and pred_target=0 while in reset. Counters/tags/targets need no reset.
- Mid-operation reset overrides everything the same instant. Training in flight is dropped.
- pc_next priority, highest first:
  1. trap_valid: trap_vec.
  2. redirect_valid: redirect_target.
  3. stall: pc_if.
  4. pred_taken: pred_target.
  5. otherwise: pc_if + 4.
- pc_if <= pc_next every rising edge. Latency: redirect visible on pc_if one cycle after assertion.
- Alignment: bits [1:0] of trap_vec, redirect_target and upd_target are forced to 0 before use or storage.
- Arithmetic: pc_if + 4 is modulo 2^XLEN. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- BTB lookup on pc_if:
  - index = pc_if[IDX_W+1:2]; tag = pc_if[XLEN-1:IDX_W+2].
  - Hit = valid & tag match. pred_taken = hit & ctr[1]; pred_target = stored target on hit, else 0.
- BTB update, synchronous on upd_valid (independent of stall/redirect/trap); index and tag taken from upd_pc:
  - Hit: ctr saturating +1 if taken, -1 if not (range 0..3). Target overwritten when taken.
  - Miss & upd_taken: allocate; valid=1, tag, target, ctr=2 (weakly taken). Replaces any occupant.
  - Miss & !upd_taken: no change.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents; update lands at the edge.
- trap_valid and redirect_valid in the same cycle: trap wins; redirect is lost (upstream responsibility).

Decomposition:
- Shared package pc_pkg:
  - constant INSN_BYTES=4.
  - typedef btb_entry_t {valid, tag, target, ctr[1:0]}.
  - counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - function sat_inc/sat_dec.
- One natural sub-module: btb_dm (storage, lookup, training). pc_gen_btb holds the PC register and next-PC mux.

Test Plan:
- Reset then 4 free-running cycles, no events -> pc_if = 0x00, 0x04, 0x08, 0x0C; pred_taken=0 throughout.
- pc_if=0x10, stall=1 for 3 cycles -> pc_if holds 0x10; first cycle after release pc_if=0x14.
- Same cycle trap_valid=1 (vec 0x80), redirect_valid=1 (0x200), stall=1 -> next pc_if=0x80.
- upd_valid with pc=0x40, target=0x103, taken=1; later fetch reaches 0x40 -> pred_taken=1, pred_target=0x100, next pc_if=0x100.
- Entry at 0x40 (ctr=2): two not-taken updates -> ctr=0, pred_taken=0 at 0x40. Three taken updates -> ctr=3; a fourth stays 3.
- Alias 0x40 vs 0x80 (16 entries) with 0x40 allocated; taken update for 0x80 -> entry replaced; fetch 0x40 gives pred_taken=0. pc_if=0xFFFF_FFFC with no events -> next 0x0. Assert reset mid-stream -> pc_if=RESET_VECTOR immediately; all predictions cleared.
